// File: rtl/usb_tx_packet_sequencer_if.sv
// usb_tx_packet_sequencer_if: request, buffer, compiler and serializer signals around the TX sequencer
interface usb_tx_packet_sequencer_if #(parameter int CNT_W = 7);
  logic [2:0]       TX_Packet;
  logic [6:0]       Buffer_Occupancy;
  logic             packet_load_complete_TX;
  logic             copy_signal;
  logic             tx_done;
  logic [2:0]       c_state_TX;
  logic [3:0]       pID;
  logic             tx_start;
  logic             TX_Transfer_Active;
  logic             TX_Error;
  logic [CNT_W-1:0] byte_count;
  modport master (
    output TX_Packet, Buffer_Occupancy, packet_load_complete_TX, copy_signal, tx_done,
    input  c_state_TX, pID, tx_start, TX_Transfer_Active, TX_Error, byte_count
  );
  modport slave (
    input  TX_Packet, Buffer_Occupancy, packet_load_complete_TX, copy_signal, tx_done,
    output c_state_TX, pID, tx_start, TX_Transfer_Active, TX_Error, byte_count
  );
endinterface

// File: rtl/usb_tx_packet_sequencer.sv
// usb_tx_packet_sequencer: control FSM driving the TX packet compiler and handing packets to the serializer
module usb_tx_packet_sequencer #(
  parameter int MAX_BYTES    = 64,
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 7
) (
  input logic clk,
  input logic n_rst,
  usb_tx_packet_sequencer_if.slave bus
);
  localparam int TO_W = $clog2(LOAD_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SYNC, PID, LOAD_WAIT, DATA, CRC, SEND, ERR} state_t;
  state_t           state_q, state_d;
  logic [2:0]       code_q, code_d;
  logic [3:0]       pid_q, pid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             start_q, start_d;
  logic [2:0]       tp;
  assign tp = bus.TX_Packet;
  // state and datapath registers; reset aborts any packet in flight
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      pid_q   <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pid_q   <= pid_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      start_q <= start_d;
    end
  end
  // next state, byte counting, load timeout and the registered tx_start pulse
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pid_d   = pid_q;
    cnt_d   = cnt_q;
    to_d    = '0;
    case (state_q)
      IDLE: begin
        if (tp != 3'd0 && tp <= 3'd5) begin
          state_d = SYNC;
          code_d  = tp;
          cnt_d   = '0;
          pid_d   = tp == 3'd1 ? 4'b0011 : tp == 3'd2 ? 4'b1011 : tp == 3'd3 ? 4'b0010 :
                    tp == 3'd4 ? 4'b1010 : 4'b1110;
        end else if (tp[2:1] == 2'b11) state_d = ERR;
      end
      SYNC: state_d = PID;
      PID:  state_d = code_q >= 3'd3 ? LOAD_WAIT : DATA;
      DATA: begin
        if (bus.Buffer_Occupancy != '0 && cnt_q < CNT_W'(MAX_BYTES)) cnt_d = cnt_q + 1'b1;
        if (bus.Buffer_Occupancy == '0 || cnt_q == CNT_W'(MAX_BYTES)) state_d = CRC;
      end
      CRC: state_d = LOAD_WAIT;
      LOAD_WAIT: begin
        to_d    = to_q + 1'b1;
        state_d = bus.packet_load_complete_TX ? SEND : to_d == TO_W'(LOAD_TIMEOUT) ? ERR : LOAD_WAIT;
        if (state_d != LOAD_WAIT) to_d = '0;
      end
      SEND:    state_d = bus.tx_done && !start_q ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
    start_d = state_d == SEND && state_q != SEND;
  end
  assign bus.c_state_TX         = state_q inside {LOAD_WAIT, SEND, ERR} ? 3'd0 : state_q;
  assign bus.pID                = pid_q;
  assign bus.tx_start           = start_q;
  assign bus.TX_Transfer_Active = state_q != IDLE;
  assign bus.TX_Error           = state_q == ERR;
  assign bus.byte_count         = cnt_q;
endmodule

// File: tb/tb_usb_tx_packet_sequencer.sv
// tb_usb_tx_packet_sequencer: scoreboard bench for the TX packet sequencer
module tb_usb_tx_packet_sequencer;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int checks = 0;
  int errors = 0;
  usb_tx_packet_sequencer_if #(.CNT_W(7)) bus();
  usb_tx_packet_sequencer #(.MAX_BYTES(64), .LOAD_TIMEOUT(16), .CNT_W(7)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] tp;
    logic [6:0] occ;
    logic       lc, td;
    logic [2:0] cs;
    logic [3:0] pid;
    logic       ts, act, err;
    logic [6:0] bc;
  } e_t;
  e_t q[$];
  e_t e;
  function automatic e_t ent(int tp, int occ, int lc, int td, int cs, int pid, int ts, int act, int err, int bc);
    e_t r;
    r.tp = 3'(tp); r.occ = 7'(occ); r.lc = 1'(lc); r.td = 1'(td);
    r.cs = 3'(cs); r.pid = 4'(pid); r.ts = 1'(ts); r.act = 1'(act); r.err = 1'(err); r.bc = 7'(bc);
    return r;
  endfunction
  task automatic test_reset();
    #2;
    checks++;
    if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !== 17'd0) begin
      errors++;
      $display("FAIL reset got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want all zero",
               bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count);
    end
    @(negedge clk);
    n_rst = 1'b1;
    q.push_back(ent(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(ent(0, 9, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      bus.TX_Packet = e.tp; bus.Buffer_Occupancy = e.occ; bus.packet_load_complete_TX = e.lc; bus.tx_done = e.td;
      @(negedge clk);
      checks++;
      if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !==
          {e.cs, e.pid, e.ts, e.act, e.err, e.bc}) begin
        errors++;
        $display("FAIL reset_idle[%0d] got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d",
                 i, bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count,
                 e.cs, e.pid, e.ts, e.act, e.err, e.bc);
      end
    end
  endtask
  task automatic test_ack();
    q.push_back(ent(3, 0, 0, 0, 1, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 2, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 1, 0, 0, 4'b0010, 1, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 1, 0, 4'b0010, 0, 0, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      bus.TX_Packet = e.tp; bus.Buffer_Occupancy = e.occ; bus.packet_load_complete_TX = e.lc; bus.tx_done = e.td;
      @(negedge clk);
      checks++;
      if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !==
          {e.cs, e.pid, e.ts, e.act, e.err, e.bc}) begin
        errors++;
        $display("FAIL ack[%0d] got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d",
                 i, bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count,
                 e.cs, e.pid, e.ts, e.act, e.err, e.bc);
      end
    end
  endtask
  task automatic test_data0();
    q.push_back(ent(1, 0, 0, 0, 1, 4'b0011, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 2, 4'b0011, 0, 1, 0, 0));
    q.push_back(ent(0, 5, 0, 0, 4, 4'b0011, 0, 1, 0, 0));
    for (int k = 5; k >= 1; k--) q.push_back(ent(0, k, 0, 0, 4, 4'b0011, 0, 1, 0, 6 - k));
    q.push_back(ent(0, 0, 0, 0, 5, 4'b0011, 0, 1, 0, 5));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b0011, 0, 1, 0, 5));
    q.push_back(ent(0, 0, 1, 0, 0, 4'b0011, 1, 1, 0, 5));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b0011, 0, 1, 0, 5));
    q.push_back(ent(0, 0, 0, 1, 0, 4'b0011, 0, 0, 0, 5));
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      bus.TX_Packet = e.tp; bus.Buffer_Occupancy = e.occ; bus.packet_load_complete_TX = e.lc; bus.tx_done = e.td;
      bus.copy_signal = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !==
          {e.cs, e.pid, e.ts, e.act, e.err, e.bc}) begin
        errors++;
        $display("FAIL data0[%0d] got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d",
                 i, bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count,
                 e.cs, e.pid, e.ts, e.act, e.err, e.bc);
      end
    end
    bus.copy_signal = 1'b0;
  endtask
  task automatic test_truncate();
    q.push_back(ent(2, 70, 0, 0, 1, 4'b1011, 0, 1, 0, 0));
    q.push_back(ent(0, 70, 0, 0, 2, 4'b1011, 0, 1, 0, 0));
    q.push_back(ent(0, 70, 0, 0, 4, 4'b1011, 0, 1, 0, 0));
    for (int k = 1; k <= 64; k++) q.push_back(ent(0, 70, 0, 0, 4, 4'b1011, 0, 1, 0, k));
    q.push_back(ent(0, 70, 0, 0, 5, 4'b1011, 0, 1, 0, 64));
    q.push_back(ent(0, 70, 0, 0, 0, 4'b1011, 0, 1, 0, 64));
    q.push_back(ent(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0, 64));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b1011, 0, 1, 0, 64));
    q.push_back(ent(0, 0, 0, 1, 0, 4'b1011, 0, 0, 0, 64));
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      bus.TX_Packet = e.tp; bus.Buffer_Occupancy = e.occ; bus.packet_load_complete_TX = e.lc; bus.tx_done = e.td;
      @(negedge clk);
      checks++;
      if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !==
          {e.cs, e.pid, e.ts, e.act, e.err, e.bc}) begin
        errors++;
        $display("FAIL truncate[%0d] got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d",
                 i, bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count,
                 e.cs, e.pid, e.ts, e.act, e.err, e.bc);
      end
    end
  endtask
  task automatic test_timeout();
    q.push_back(ent(3, 0, 0, 0, 1, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 2, 4'b0010, 0, 1, 0, 0));
    for (int k = 0; k < 16; k++) q.push_back(ent(0, 0, 0, 0, 0, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b0010, 0, 1, 1, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
    q.push_back(ent(0, 0, 0, 1, 0, 4'b0010, 0, 0, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      bus.TX_Packet = e.tp; bus.Buffer_Occupancy = e.occ; bus.packet_load_complete_TX = e.lc; bus.tx_done = e.td;
      @(negedge clk);
      checks++;
      if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !==
          {e.cs, e.pid, e.ts, e.act, e.err, e.bc}) begin
        errors++;
        $display("FAIL timeout[%0d] got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d",
                 i, bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count,
                 e.cs, e.pid, e.ts, e.act, e.err, e.bc);
      end
    end
  endtask
  task automatic test_timeout_edge();
    q.push_back(ent(5, 0, 0, 0, 1, 4'b1110, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 2, 4'b1110, 0, 1, 0, 0));
    for (int k = 0; k < 16; k++) q.push_back(ent(0, 0, 0, 0, 0, 4'b1110, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 1, 0, 0, 4'b1110, 1, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b1110, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 1, 0, 4'b1110, 0, 0, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      bus.TX_Packet = e.tp; bus.Buffer_Occupancy = e.occ; bus.packet_load_complete_TX = e.lc; bus.tx_done = e.td;
      @(negedge clk);
      checks++;
      if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !==
          {e.cs, e.pid, e.ts, e.act, e.err, e.bc}) begin
        errors++;
        $display("FAIL timeout_edge[%0d] got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d",
                 i, bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count,
                 e.cs, e.pid, e.ts, e.act, e.err, e.bc);
      end
    end
  endtask
  task automatic test_invalid();
    q.push_back(ent(7, 0, 0, 0, 0, 4'b1110, 0, 1, 1, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b1110, 0, 0, 0, 0));
    q.push_back(ent(6, 0, 0, 0, 0, 4'b1110, 0, 1, 1, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b1110, 0, 0, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b1110, 0, 0, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      bus.TX_Packet = e.tp; bus.Buffer_Occupancy = e.occ; bus.packet_load_complete_TX = e.lc; bus.tx_done = e.td;
      @(negedge clk);
      checks++;
      if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !==
          {e.cs, e.pid, e.ts, e.act, e.err, e.bc}) begin
        errors++;
        $display("FAIL invalid[%0d] got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d",
                 i, bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count,
                 e.cs, e.pid, e.ts, e.act, e.err, e.bc);
      end
    end
  endtask
  task automatic test_back_to_back();
    q.push_back(ent(3, 0, 0, 0, 1, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 2, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 1, 0, 0, 4'b0010, 1, 1, 0, 0));
    q.push_back(ent(4, 0, 0, 1, 0, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(4, 0, 0, 0, 0, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(4, 0, 0, 0, 0, 4'b0010, 0, 1, 0, 0));
    q.push_back(ent(4, 0, 0, 1, 0, 4'b0010, 0, 0, 0, 0));
    q.push_back(ent(4, 0, 0, 0, 1, 4'b1010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 2, 4'b1010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b1010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 1, 0, 0, 4'b1010, 1, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 0, 0, 4'b1010, 0, 1, 0, 0));
    q.push_back(ent(0, 0, 0, 1, 0, 4'b1010, 0, 0, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      bus.TX_Packet = e.tp; bus.Buffer_Occupancy = e.occ; bus.packet_load_complete_TX = e.lc; bus.tx_done = e.td;
      @(negedge clk);
      checks++;
      if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !==
          {e.cs, e.pid, e.ts, e.act, e.err, e.bc}) begin
        errors++;
        $display("FAIL back_to_back[%0d] got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d",
                 i, bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count,
                 e.cs, e.pid, e.ts, e.act, e.err, e.bc);
      end
    end
  endtask
  task automatic test_reset_mid();
    q.push_back(ent(1, 3, 0, 0, 1, 4'b0011, 0, 1, 0, 0));
    q.push_back(ent(0, 3, 0, 0, 2, 4'b0011, 0, 1, 0, 0));
    q.push_back(ent(0, 3, 0, 0, 4, 4'b0011, 0, 1, 0, 0));
    q.push_back(ent(0, 3, 0, 0, 4, 4'b0011, 0, 1, 0, 1));
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      bus.TX_Packet = e.tp; bus.Buffer_Occupancy = e.occ; bus.packet_load_complete_TX = e.lc; bus.tx_done = e.td;
      @(negedge clk);
      checks++;
      if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !==
          {e.cs, e.pid, e.ts, e.act, e.err, e.bc}) begin
        errors++;
        $display("FAIL reset_mid_pre[%0d] got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d",
                 i, bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count,
                 e.cs, e.pid, e.ts, e.act, e.err, e.bc);
      end
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want all zero",
               bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 6; k++) q.push_back(ent(0, 3, 1, k % 2, 0, 0, 0, 0, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      bus.TX_Packet = e.tp; bus.Buffer_Occupancy = e.occ; bus.packet_load_complete_TX = e.lc; bus.tx_done = e.td;
      @(negedge clk);
      checks++;
      if ({bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count} !==
          {e.cs, e.pid, e.ts, e.act, e.err, e.bc}) begin
        errors++;
        $display("FAIL reset_mid_post[%0d] got cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d want cs=%0d pid=%b ts=%b act=%b err=%b bc=%0d",
                 i, bus.c_state_TX, bus.pID, bus.tx_start, bus.TX_Transfer_Active, bus.TX_Error, bus.byte_count,
                 e.cs, e.pid, e.ts, e.act, e.err, e.bc);
      end
    end
  endtask
  initial begin
    bus.TX_Packet = '0;
    bus.Buffer_Occupancy = '0;
    bus.packet_load_complete_TX = 1'b0;
    bus.copy_signal = 1'b0;
    bus.tx_done = 1'b0;
    test_reset();
    test_ack();
    test_data0();
    test_truncate();
    test_timeout();
    test_timeout_edge();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_tx_packet_sequencer.md
Name: usb_tx_packet_sequencer

Overview:
- Control FSM for the TX packet compiler datapath.
- Accepts a packet request from the protocol layer and drives the compiler's state code (c_state_TX) and PID.
- Waits for the compiled packet to be loaded, then hands it to the TX serializer and tracks completion.
- Sits between the USB protocol controller, the TX data buffer, the packet compiler and the bit-level encoder.

Parameters:
- MAX_BYTES, 64, maximum data payload bytes per packet before forced end of data.
- LOAD_TIMEOUT, 16, cycles allowed in LOAD_WAIT for packet_load_complete_TX before error.
- CNT_W, 7, width of the internal data byte counter (must hold MAX_BYTES).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- TX_Packet  in  3  request code: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 invalid.
- Buffer_Occupancy  in  7  bytes currently held in the TX data buffer.
- packet_load_complete_TX  in  1  compiler reports the packet image is complete.
- copy_signal  in  1  compiler pulse indicating the image was copied.
- tx_done  in  1  serializer pulse: packet fully transmitted, EOP sent.
- c_state_TX  out  3  state code to the compiler: 0 idle, 1 sync, 2 pid, 4 data, 5 crc/end.
- pID  out  4  PID nibble to the compiler.
- tx_start  out  1  one-cycle pulse to the serializer to begin sending.
- TX_Transfer_Active  out  1  high whenever the FSM is not IDLE.
- TX_Error  out  1  one-cycle error pulse.
- byte_count  out  CNT_W  data bytes requested in the current packet.

Behaviour:
- Reset (async, n_rst=0): state IDLE.
  - c_state_TX=0, pID=0, tx_start=0, TX_Transfer_Active=0, TX_Error=0, byte_count=0, timeout counter=0.
  - Reset mid-packet aborts immediately; no tx_start is issued afterwards.
- All outputs are registered or decoded from the registered state only; no combinational path from inputs to outputs.
- States and encodings:
  - IDLE=0, SYNC=1, PID=2, LOAD_WAIT=3, DATA=4, CRC=5, SEND=6, ERR=7.
  - c_state_TX presents the state code, except LOAD_WAIT, SEND and ERR, which present 0.
- IDLE:
  - TX_Packet in 1..5: latch the code, load the pID register, clear byte_count, go to SYNC.
  - TX_Packet in 6/7: go to ERR.
  - TX_Packet=0: stay.
- pID mapping, held constant from SYNC until return to IDLE:
  - DATA0 = 4'b0011, DATA1 = 4'b1011, ACK = 4'b0010, NAK = 4'b1010, STALL = 4'b1110.
- SYNC: 1 cycle, then PID.
- PID: 1 cycle. Handshake (ACK/NAK/STALL) goes to LOAD_WAIT; DATA0/DATA1 goes to DATA.
- DATA:
  - Each cycle with Buffer_Occupancy!=0 and byte_count<MAX_BYTES: byte_count+1.
  - Go to CRC when Buffer_Occupancy==0, or when byte_count==MAX_BYTES (truncation; remaining buffer bytes are not consumed).
  - A zero-length packet (occupancy 0 on entry) stays 1 cycle, then goes to CRC.
- CRC: 1 cycle, then LOAD_WAIT.
- LOAD_WAIT:
  - Timeout counter increments every cycle.
  - packet_load_complete_TX=1 goes to SEND.
  - Counter reaching LOAD_TIMEOUT without completion goes to ERR; completion on that same cycle wins, going to SEND.
  - Counter is cleared on exit.
- SEND:
  - tx_start=1 on the first cycle in SEND only.
  - Wait for tx_done, then go to IDLE.
  - tx_done coincident with the tx_start cycle is ignored; only tx_done on a later cycle counts.
- ERR: TX_Error=1 for exactly 1 cycle, then IDLE.
- TX_Packet changes outside IDLE are ignored.
- A new request is accepted on the cycle after returning to IDLE, not on the return cycle.
- copy_signal is informational only; it does not gate any transition.

Test Plan:
- Reset, then TX_Packet=3 (ACK) for 1 cycle -> c_state_TX 1,2,0; pID=0010.
  - Raise packet_load_complete_TX 2 cycles later -> tx_start one cycle pulse; tx_done -> IDLE, TX_Transfer_Active falls.
- TX_Packet=1 with Buffer_Occupancy counting down 5..1 then 0 -> c_state_TX 1,2,4×6,5; byte_count=5; pID=0011; then SEND on load complete.
- TX_Packet=2 with Buffer_Occupancy held at 70 -> DATA exits at byte_count=64 into CRC; pID=1011.
- ACK request with packet_load_complete_TX never asserted -> after 16 cycles in LOAD_WAIT: TX_Error pulse 1 cycle, return to IDLE, no tx_start.
- TX_Packet=7 in IDLE -> TX_Error pulse, no SYNC.
  - Separately, assert n_rst low during DATA -> all outputs 0 immediately; no tx_start after release.
- tx_done asserted on the tx_start cycle and again 3 cycles later -> FSM leaves SEND only on the second pulse.
  - A TX_Packet=4 held during SEND is ignored until the cycle after IDLE is reached.
